display_mux_ctrl: RTL and testbench

DISPLAY_MUX_CTRL -- requirements
Module: display_mux_ctrl

---
 rtl/display_mux_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_display_mux_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl
//   Converts a signed 16-bit value to BCD (serial double-dabble) and drives a
//   multiplexed common-digit seven-segment display, with optional blinking.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   scan_en    single-cycle pulse that advances the scanned digit
//   val_data   signed two's-complement value in display units
//   val_valid  val_data / dp_pos offered
//   val_ready  converter idle; a transfer happens when val_valid && val_ready
//   dp_pos     number of fractional digits (0 = no decimal point)
//   blink      blink enable
//   seven_seg  segments gfedcba, active high
//   dp         decimal point segment, active high
//   digit_sel  one-hot-low digit enable, bit 0 = rightmost digit
//
// Handshake: val_valid/val_ready follow valid/ready semantics. val_data and
// dp_pos are captured on the clk edge where both are 1. val_ready drops for
// exactly 17 cycles (16 conversion steps + 1 commit); offers made while
// val_ready is 0 are ignored, never queued.

module display_mux_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int BLINK_TICKS = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_en,
    input  logic [15:0]                   val_data,
    input  logic                          val_valid,
    output logic                          val_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] dp_pos,
    input  logic                          blink,
    output logic [6:0]                    seven_seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         digit_sel
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0]    SEG_MINUS  = 7'b1000000;
    localparam logic [31:0]   POS_MAX    = 32'(10 ** NUM_DIGITS - 1);
    localparam logic [31:0]   NEG_MAX    = 32'(10 ** (NUM_DIGITS - 1) - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    BLINK_LAST = 7'(BLINK_TICKS - 1);

    // converter state
    logic [1:0]    state;
    logic [15:0]   bin_sr;
    logic [19:0]   bcd_sr;
    logic [3:0]    step_cnt;
    logic          cap_neg;
    logic [15:0]   cap_mag;
    logic [IW-1:0] cap_dp;

    // display register
    logic [DW-1:0] disp_bcd;
    logic          disp_neg;
    logic          disp_ovf;
    logic [IW-1:0] disp_dp;

    // scan / blink state
    logic [IW-1:0] idx;
    logic [6:0]    blink_cnt;
    logic          blink_state;

    logic          xfer;
    logic [15:0]   mag_in;
    logic [IW-1:0] dp_clean;
    logic [35:0]   adj;
    logic [35:0]   dabble_next;
    logic          ovf_next;

    assign val_ready = (state == S_IDLE);
    assign xfer      = val_valid && val_ready;

    // |val_data| as unsigned; -32768 maps to 0x8000 = 32768.
    assign mag_in = val_data[15] ? (~val_data + 16'd1) : val_data;

    // Out-of-range dp_pos codes only exist when NUM_DIGITS is not a power of 2.
    generate
        if ((2 ** IW) > NUM_DIGITS) begin : g_dp_clamp
            assign dp_clean = (dp_pos > IDX_LAST) ? '0 : dp_pos;
        end else begin : g_dp_pass
            assign dp_clean = dp_pos;
        end
    endgenerate

    // One double-dabble step on {bcd, bin}: add 3 to BCD nibbles >= 5, shift left.
    always_comb begin
        adj = {bcd_sr, bin_sr};
        for (int n = 0; n < 5; n++) begin
            if (adj[16 + 4*n +: 4] >= 4'd5) begin
                adj[16 + 4*n +: 4] = adj[16 + 4*n +: 4] + 4'd3;
            end
        end
        dabble_next = adj << 1;
    end

    assign ovf_next = cap_neg ? ({16'd0, cap_mag} > NEG_MAX)
                              : ({16'd0, cap_mag} > POS_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            step_cnt <= '0;
            cap_neg  <= 1'b0;
            cap_mag  <= '0;
            cap_dp   <= '0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            disp_ovf <= 1'b0;
            disp_dp  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        bin_sr   <= mag_in;
                        bcd_sr   <= '0;
                        step_cnt <= '0;
                        cap_neg  <= val_data[15];
                        cap_mag  <= mag_in;
                        cap_dp   <= dp_clean;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    {bcd_sr, bin_sr} <= dabble_next;
                    step_cnt         <= step_cnt + 4'd1;
                    if (step_cnt == 4'd15) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    disp_bcd <= bcd_sr[DW-1:0];
                    disp_neg <= cap_neg;
                    disp_ovf <= ovf_next;
                    disp_dp  <= cap_dp;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Digit index and blink counter, both advanced by scan_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            blink_cnt   <= '0;
            blink_state <= 1'b1;
        end else if (scan_en) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_state <= ~blink_state;
            end else begin
                blink_cnt <= blink_cnt + 7'd1;
            end
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0111111;
            4'd1:    seg_of = 7'b0000110;
            4'd2:    seg_of = 7'b1011011;
            4'd3:    seg_of = 7'b1001111;
            4'd4:    seg_of = 7'b1100110;
            4'd5:    seg_of = 7'b1101101;
            4'd6:    seg_of = 7'b1111101;
            4'd7:    seg_of = 7'b0000111;
            4'd8:    seg_of = 7'b1111111;
            4'd9:    seg_of = 7'b1101111;
            default: seg_of = 7'b0000000;
        endcase
    endfunction

    logic [IW-1:0] msnz;
    logic [IW-1:0] lead_idx;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_next;
    logic          dp_next;

    // Leftmost shown digit is the higher of the most significant nonzero digit
    // and the decimal point position; everything up to it is shown, the minus
    // sign sits one place further left.
    always_comb begin
        msnz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                msnz = IW'(i);
            end
        end
        lead_idx  = (disp_dp > msnz) ? disp_dp : msnz;
        cur_digit = disp_bcd[{idx, 2'b00} +: 4];

        seg_next = 7'd0;
        dp_next  = 1'b0;
        if (disp_ovf) begin
            seg_next = SEG_MINUS;
        end else if (idx <= lead_idx) begin
            seg_next = seg_of(cur_digit);
            dp_next  = (idx == disp_dp) && (disp_dp != '0);
        end else if (disp_neg && ({1'b0, idx} == ({1'b0, lead_idx} + 1'b1))) begin
            // widened compare so lead_idx + 1 cannot wrap onto index 0
            seg_next = SEG_MINUS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seven_seg <= '0;
            dp        <= 1'b0;
            digit_sel <= '1;
        end else if (blink && !blink_state) begin
            seven_seg <= '0;
            dp        <= 1'b0;
            digit_sel <= '1;
        end else begin
            seven_seg <= seg_next;
            dp        <= dp_next;
            digit_sel <= ~(NUM_DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// tb_display_mux_ctrl
//   Bench for display_mux_ctrl with NUM_DIGITS=4, BLINK_TICKS=50.
//   Fixed vector table with hand-written expected segments, hand-written
//   sequences for handshake, reset-during-conversion and blink, and random
//   values checked against an arithmetic reference model.

module tb_display_mux_ctrl;

    localparam int N = 4;

    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P5 = 7'b1101101;
    localparam logic [6:0] P6 = 7'b1111101;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1101111;
    localparam logic [6:0] MN = 7'b1000000;
    localparam logic [6:0] BL = 7'b0000000;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic [15:0] val_data;
    logic       val_valid;
    logic       val_ready;
    logic [1:0] dp_pos;
    logic       blink;
    logic [6:0] seven_seg;
    logic       dp;
    logic [3:0] digit_sel;

    display_mux_ctrl #(
        .NUM_DIGITS (4),
        .BLINK_TICKS(50)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .val_data (val_data),
        .val_valid(val_valid),
        .val_ready(val_ready),
        .dp_pos   (dp_pos),
        .blink    (blink),
        .seven_seg(seven_seg),
        .dp       (dp),
        .digit_sel(digit_sel)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int checks;
    int errors;
    int tb_idx;
    int model_val;
    int model_dp;

    typedef struct {
        int          value;
        int          dpp;
        logic [27:0] seg;   // {idx3, idx2, idx1, idx0}
        logic [3:0]  dpv;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d act=%0h exp=%0h", name, tb_idx, act, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return P0;
            1: return P1;
            2: return P2;
            3: return P3;
            4: return P4;
            5: return P5;
            6: return P6;
            7: return P7;
            8: return P8;
            default: return P9;
        endcase
    endfunction

    // Reference: what digit i of an N-digit display shows for a value.
    function automatic void model_digit(input int value, input int dpp, input int i,
                                        output logic [6:0] seg, output logic dpo);
        int  mag;
        int  nd;
        int  lead;
        bit  neg;
        neg = (value < 0);
        mag = neg ? -value : value;
        seg = BL;
        dpo = 1'b0;
        if ((neg && mag > 10 ** (N - 1) - 1) || (!neg && mag > 10 ** N - 1)) begin
            seg = MN;
            return;
        end
        nd = 1;
        while (nd < 6 && mag >= 10 ** nd) nd++;
        lead = (nd - 1 > dpp) ? nd - 1 : dpp;
        if (i <= lead) begin
            seg = pat((mag / (10 ** i)) % 10);
            dpo = (i == dpp) && (dpp != 0);
        end else if (neg && i == lead + 1) begin
            seg = MN;
        end
    endfunction

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        tb_idx    = 0;
        model_val = 0;
        model_dp  = 0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (val_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, val_ready, 1);
    endtask

    task automatic send(input int value, input int dpp);
        wait_ready("ready_before_send");
        val_data  = 16'(value);
        dp_pos    = 2'(dpp);
        val_valid = 1'b1;
        @(posedge clk); #1;
        val_valid = 1'b0;
        for (int c = 0; c < 17; c++) begin
            check("busy_low", val_ready, 0);
            @(posedge clk); #1;
        end
        check("ready_after_17", val_ready, 1);
        model_val = value;
        model_dp  = dpp;
    endtask

    task automatic scan_pulse();
        scan_en = 1'b1;
        @(posedge clk); #1;
        scan_en = 1'b0;
        tb_idx  = (tb_idx + 1) % N;
        @(posedge clk); #1;
    endtask

    task automatic check_model_digit(input string name);
        logic [6:0] es;
        logic       ed;
        model_digit(model_val, model_dp, tb_idx, es, ed);
        check({name, "_seg"}, seven_seg, es);
        check({name, "_dp"}, dp, ed);
        check({name, "_sel"}, digit_sel, 4'b1111 ^ (4'b0001 << tb_idx));
    endtask

    task automatic scan_model(input string name);
        for (int p = 0; p < N; p++) begin
            scan_pulse();
            check_model_digit(name);
        end
    endtask

    task automatic scan_vec(input int v);
        logic [27:0] s;
        logic [3:0]  d;
        s = vecs[v].seg;
        d = vecs[v].dpv;
        for (int p = 0; p < N; p++) begin
            scan_pulse();
            check($sformatf("vec%0d_seg", v), seven_seg, s[7*tb_idx +: 7]);
            check($sformatf("vec%0d_dp", v), dp, d[tb_idx]);
            check($sformatf("vec%0d_sel", v), digit_sel, 4'b1111 ^ (4'b0001 << tb_idx));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        tb_idx    = 0;
        model_val = 0;
        model_dp  = 0;
        rst_n     = 1'b0;
        scan_en   = 1'b0;
        val_data  = '0;
        val_valid = 1'b0;
        dp_pos    = '0;
        blink     = 1'b0;

        vecs[0]  = '{235,    1, {BL, P2, P3, P5}, 4'b0010};
        vecs[1]  = '{-5,     1, {BL, MN, P0, P5}, 4'b0010};
        vecs[2]  = '{12345,  0, {MN, MN, MN, MN}, 4'b0000};
        vecs[3]  = '{-1000,  0, {MN, MN, MN, MN}, 4'b0000};
        vecs[4]  = '{-999,   0, {MN, P9, P9, P9}, 4'b0000};
        vecs[5]  = '{7,      2, {BL, P0, P0, P7}, 4'b0100};
        vecs[6]  = '{9999,   3, {P9, P9, P9, P9}, 4'b1000};
        vecs[7]  = '{-32768, 0, {MN, MN, MN, MN}, 4'b0000};
        vecs[8]  = '{0,      0, {BL, BL, BL, P0}, 4'b0000};
        vecs[9]  = '{-7,     0, {BL, BL, MN, P7}, 4'b0000};
        vecs[10] = '{10000,  0, {MN, MN, MN, MN}, 4'b0000};
        vecs[11] = '{-99,    3, {P0, P0, P9, P9}, 4'b1000};

        // reset state
        @(posedge clk); #1;
        check("rst_seg", seven_seg, 0);
        check("rst_dp", dp, 0);
        check("rst_sel", digit_sel, 4'b1111);
        check("rst_ready", val_ready, 1);
        rst_n = 1'b1;

        // display after reset holds value 0
        scan_model("after_reset");

        // fixed vectors
        for (int v = 0; v < 12; v++) begin
            send(vecs[v].value, vecs[v].dpp);
            scan_vec(v);
        end

        // valid held through busy: 235 taken, 7 ignored until ready returns
        wait_ready("hs_ready_initial");
        val_data  = 16'd235;
        dp_pos    = 2'd1;
        val_valid = 1'b1;
        @(posedge clk); #1;
        val_data = 16'd7;
        for (int c = 0; c < 17; c++) begin
            check("hs_busy_low", val_ready, 0);
            @(posedge clk); #1;
        end
        check("hs_ready_return", val_ready, 1);
        @(posedge clk); #1;
        val_valid = 1'b0;
        check("hs_second_accept", val_ready, 0);
        wait_ready("hs_ready_final");
        model_val = 7;
        model_dp  = 1;
        scan_model("hs_result");

        // reset in the middle of converting 88
        wait_ready("rc_ready");
        val_data  = 16'd88;
        dp_pos    = 2'd0;
        val_valid = 1'b1;
        @(posedge clk); #1;
        val_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rc_ready_after_rst", val_ready, 1);
        check("rc_seg_after_rst", seven_seg, 0);
        rst_n     = 1'b1;
        tb_idx    = 0;
        model_val = 0;
        model_dp  = 0;
        repeat (25) begin
            @(posedge clk); #1;
        end
        check("rc_ready_later", val_ready, 1);
        scan_model("rc_display");

        // blink: starts right after reset so the blink counter is at 0
        do_reset();
        send(235, 1);
        blink = 1'b1;
        for (int p = 1; p <= 150; p++) begin
            scan_pulse();
            if ((p >= 50 && p <= 99) || p >= 150) begin
                check("blink_off_seg", seven_seg, 0);
                check("blink_off_dp", dp, 0);
                check("blink_off_sel", digit_sel, 4'b1111);
            end else begin
                check_model_digit("blink_on");
            end
        end
        blink = 1'b0;
        @(posedge clk); #1;
        check_model_digit("blink_release");

        // random values against the reference model
        for (int r = 0; r < 40; r++) begin
            int value;
            int dpp;
            case ($urandom_range(0, 3))
                0:       value = int'($urandom_range(0, 65535)) - 32768;
                1:       value = int'($urandom_range(0, 9999));
                2:       value = -int'($urandom_range(0, 999));
                default: value = int'($urandom_range(0, 99));
            endcase
            dpp = int'($urandom_range(0, 3));
            send(value, dpp);
            scan_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
